store_align_unit: RTL and testbench
===================================

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
- REQ-001 SHALL have parameter BUS_BYTES, default 8, meaning data-bus width in bytes; legal values 4 or 8.
- REQ-002 SHALL have parameter SPLIT_EN, default 1, meaning 1: a line-crossing store is split into two beats; 0: it is reported as misaligned.
- REQ-003 SHALL have port clk, input, 1, meaning the single clock.
- REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
- REQ-005 SHALL have port in_valid, input, 1, meaning a store request is present.
- REQ-006 SHALL have port in_ready, output, 1, meaning the unit accepts a store this cycle.
- REQ-007 SHALL have port in_addr, input, 64, meaning the byte address of the store.
- REQ-008 SHALL have port in_data, input, 64, meaning store data, right-justified.
- REQ-009 SHALL have port in_msize, input, msize_t, meaning MSIZE1/2/4/8 (1/2/4/8 bytes).
- REQ-010 SHALL have port req_valid, output, 1, meaning a bus write beat is valid.
- REQ-011 SHALL have port req_ready, input, 1, meaning the bus accepts the beat.
- REQ-012 SHALL have port req_addr, output, 64, meaning the beat address, aligned to BUS_BYTES.
- REQ-013 SHALL have port req_data, output, 8*BUS_BYTES, meaning the lane-aligned beat data.
- REQ-014 SHALL have port req_strobe, output, BUS_BYTES, meaning byte enables.
- REQ-015 SHALL have port resp_ok, input, 1, meaning the bus has completed the outstanding beat.
- REQ-016 SHALL have port done, output, 1, meaning a one-cycle pulse at store completion.
- REQ-017 SHALL have port misalign, output, 1, meaning it is qualified by done and set when the store was rejected.

Function
- REQ-018 SHALL implement states IDLE, REQ0, WAIT0, REQ1, WAIT1, FIN; in_ready=1 only in IDLE.
- REQ-019 SHALL, on in_valid&&in_ready, register the address, data and size, and compute these values:
  - off = in_addr mod BUS_BYTES;
  - wide data = in_data << 8*off, over 16*BUS_BYTES bits;
  - wide strobe = ((1<<size_bytes)-1) << off, over 2*BUS_BYTES bits.
- REQ-020 SHALL drive beat0 with the low half of the wide data and strobe, at address in_addr with its low log2(BUS_BYTES) bits cleared.
- REQ-021 SHALL drive beat1 with the high half of the wide data and strobe, at address beat0 address + BUS_BYTES.
- REQ-022 SHALL call a store crossing when the high strobe half is nonzero.
- REQ-023 SHALL call a store illegal when it is crossing and SPLIT_EN=0.
- REQ-024 SHALL also call a store illegal when size_bytes > BUS_BYTES and off != 0.
- REQ-025 SHALL move an accepted store from IDLE to FIN when it is illegal, with misalign=1 at done and no bus beat issued.
- REQ-026 SHALL move an accepted legal store from IDLE to REQ0.
- REQ-027 SHALL assert req_valid in REQ0/REQ1 only; req_addr, req_data and req_strobe SHALL stay stable until req_ready.
- REQ-028 SHALL move REQ0 to WAIT0 on req_ready, and WAIT0 to REQ1 (crossing) or FIN (not crossing) on resp_ok.
- REQ-029 SHALL move REQ1 to WAIT1 on req_ready, and WAIT1 to FIN on resp_ok.
- REQ-030 SHALL ignore resp_ok outside WAIT0/WAIT1.
- REQ-031 SHALL, in FIN, assert done for exactly one cycle, then return to IDLE.
- REQ-032 SHALL give a minimum latency, accept to done, of 3 cycles for a single beat and 5 cycles for a split store, with req_ready/resp_ok high at first opportunity; an illegal store SHALL reach done in 1 cycle.
- REQ-033 SHALL hold req_data lanes whose strobe is 0 at 0.
- REQ-034 SHALL compute beat addresses modulo 2^64, so that 0xFFFF_FFFF_FFFF_FFF8 + 8 wraps to 0.

Reset
- REQ-035 SHALL, while reset=1, immediately force state IDLE, in_ready=1, req_valid=0, req_addr=0, req_data=0, req_strobe=0, done=0 and misalign=0.
- REQ-036 SHALL, on reset mid-operation (any state), drop the outstanding store with no done pulse, and ignore any later resp_ok until a new beat is issued.

Verification
- REQ-037 SHALL be verified (BUS_BYTES=8): MSIZE1, addr 0x1003, data 0xAB -> one beat, addr 0x1000, strobe 0x08, data 0x00000000AB000000; done 3 cycles after accept, misalign=0.
- REQ-038 SHALL be verified: MSIZE4, addr 0x2006, data 0x11223344, SPLIT_EN=1 -> beat0 addr 0x2000, strobe 0xC0, data[63:48]=0x3344; beat1 addr 0x2008, strobe 0x03, data[15:0]=0x1122; done after the second resp_ok.
- REQ-039 SHALL be verified: the REQ-038 store with SPLIT_EN=0 -> no req_valid; done=1 with misalign=1 in the cycle after accept.
- REQ-040 SHALL be verified: MSIZE8, addr 0x3000, with req_ready held low 3 cycles -> req_valid and the beat fields are stable all 4 cycles; strobe 0xFF.
- REQ-041 SHALL be verified: BUS_BYTES=4, MSIZE8, addr 0x4000, data 0x8877665544332211 -> beat0 0x4000/0xF/0x44332211; beat1 0x4004/0xF/0x88776655.
- REQ-042 SHALL be verified: reset asserted in WAIT1 -> outputs at reset values immediately; a subsequent resp_ok produces no done; next accept works normally.

Source files
------------

// File: rtl/store_align_unit.sv
// Store alignment unit: turns a right-justified store of 1/2/4/8 bytes into one or
// two lane-aligned bus write beats with byte strobes, or rejects it as misaligned.
package store_align_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;
endpackage

module store_align_unit
  import store_align_pkg::*;
#(
  parameter int BUS_BYTES = 8,
  parameter bit SPLIT_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_addr,
  input  logic [63:0]            in_data,
  input  msize_t                 in_msize,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [63:0]            req_addr,
  output logic [8*BUS_BYTES-1:0] req_data,
  output logic [BUS_BYTES-1:0]   req_strobe,
  input  logic                   resp_ok,
  output logic                   done,
  output logic                   misalign
);

  localparam int OFF_W = $clog2(BUS_BYTES);
  localparam int SW    = 2 * BUS_BYTES;
  localparam int BW    = 8 * BUS_BYTES;
  localparam int DW    = 2 * BW;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, FIN} state_t;

  state_t            state_q, state_d;
  logic [63:0]       base_q, base_d;
  logic [DW-1:0]     data_q, data_d;
  logic [SW-1:0]     strobe_q, strobe_d;
  logic              crossing_q, crossing_d;
  logic              illegal_q, illegal_d;

  logic [OFF_W-1:0]  off;
  logic [3:0]        size_bytes;
  logic [SW-1:0]     size_mask;
  logic              accept;
  logic              hi_beat;

  assign accept = in_valid && (state_q == IDLE);

  // Alignment datapath: both beats are formed at accept time from one double-width shift.
  // NOTE: every signal assigned in always_comb gets a value first, so no latch is inferred.
  always_comb begin
    off        = in_addr[OFF_W-1:0];
    size_bytes = 4'd1;
    size_mask  = SW'(8'h01);
    unique case (in_msize)
      MSIZE1: begin size_bytes = 4'd1; size_mask = SW'(8'h01); end
      MSIZE2: begin size_bytes = 4'd2; size_mask = SW'(8'h03); end
      MSIZE4: begin size_bytes = 4'd4; size_mask = SW'(8'h0F); end
      MSIZE8: begin size_bytes = 4'd8; size_mask = SW'(8'hFF); end
    endcase
    strobe_d = size_mask << off;
    data_d   = DW'(in_data) << {off, 3'b000};
    for (int i = 0; i < SW; i++) begin
      if (!strobe_d[i]) data_d[8*i +: 8] = 8'h00;
    end
    crossing_d = |strobe_d[SW-1:BUS_BYTES];
    illegal_d  = (crossing_d && !SPLIT_EN) ||
                 ((size_bytes > 4'(BUS_BYTES)) && (off != '0));
    base_d     = {in_addr[63:OFF_W], {OFF_W{1'b0}}};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      data_q     <= '0;
      strobe_q   <= '0;
      crossing_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q     <= base_d;
        data_q     <= data_d;
        strobe_q   <= strobe_d;
        crossing_q <= crossing_d;
        illegal_q  <= illegal_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept)    state_d = illegal_d ? FIN : REQ0;
      REQ0:  if (req_ready) state_d = WAIT0;
      WAIT0: if (resp_ok)   state_d = crossing_q ? REQ1 : FIN;
      REQ1:  if (req_ready) state_d = WAIT1;
      WAIT1: if (resp_ok)   state_d = FIN;
      FIN:                  state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Beat fields come straight from registers, so they hold steady while req_ready is low.
  always_comb begin
    hi_beat    = (state_q == REQ1) || (state_q == WAIT1);
    in_ready   = (state_q == IDLE);
    req_valid  = (state_q == REQ0) || (state_q == REQ1);
    req_addr   = base_q + (hi_beat ? 64'(BUS_BYTES) : 64'd0);
    req_data   = hi_beat ? data_q[DW-1:BW] : data_q[BW-1:0];
    req_strobe = hi_beat ? strobe_q[SW-1:BUS_BYTES] : strobe_q[BUS_BYTES-1:0];
    done       = (state_q == FIN);
    misalign   = (state_q == FIN) && illegal_q;
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Self-checking bench for store_align_unit: three instances (8-byte split, 8-byte
// no-split, 4-byte split) checked against a byte-level reference model.
module tb_store_align_unit;
  import store_align_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, req_ready, resp_ok;
  logic [63:0] in_addr, in_data;
  msize_t      in_msize;
  int          sel;

  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2, dn0, dn1, dn2, mis0, mis1, mis2;
  logic [63:0] adr0, adr1, adr2, dat0, dat1;
  logic [31:0] dat2;
  logic [7:0]  stb0, stb1;
  logic [3:0]  stb2;

  logic        obs_ready, obs_valid, obs_done, obs_mis;
  logic [63:0] obs_addr, obs_data;
  logic [7:0]  obs_strobe;

  int checks = 0;
  int errors = 0;

  logic [63:0] e_addr[2], e_data[2], ob_addr[2], ob_data[2];
  logic [7:0]  e_strb[2], ob_strb[2];
  bit          e_illegal;
  int          e_nb;

  always #5 clk = ~clk;

  store_align_unit #(.BUS_BYTES(8), .SPLIT_EN(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 0), .in_ready(rdy0),
    .in_addr(in_addr), .in_data(in_data), .in_msize(in_msize),
    .req_valid(vld0), .req_ready(req_ready), .req_addr(adr0), .req_data(dat0),
    .req_strobe(stb0), .resp_ok(resp_ok), .done(dn0), .misalign(mis0));

  store_align_unit #(.BUS_BYTES(8), .SPLIT_EN(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 1), .in_ready(rdy1),
    .in_addr(in_addr), .in_data(in_data), .in_msize(in_msize),
    .req_valid(vld1), .req_ready(req_ready), .req_addr(adr1), .req_data(dat1),
    .req_strobe(stb1), .resp_ok(resp_ok), .done(dn1), .misalign(mis1));

  store_align_unit #(.BUS_BYTES(4), .SPLIT_EN(1'b1)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 2), .in_ready(rdy2),
    .in_addr(in_addr), .in_data(in_data), .in_msize(in_msize),
    .req_valid(vld2), .req_ready(req_ready), .req_addr(adr2), .req_data(dat2),
    .req_strobe(stb2), .resp_ok(resp_ok), .done(dn2), .misalign(mis2));

  always_comb begin
    obs_ready = rdy0; obs_valid = vld0; obs_done = dn0; obs_mis = mis0;
    obs_addr = adr0; obs_data = dat0; obs_strobe = stb0;
    if (sel == 1) begin
      obs_ready = rdy1; obs_valid = vld1; obs_done = dn1; obs_mis = mis1;
      obs_addr = adr1; obs_data = dat1; obs_strobe = stb1;
    end else if (sel == 2) begin
      obs_ready = rdy2; obs_valid = vld2; obs_done = dn2; obs_mis = mis2;
      obs_addr = adr2; obs_data = {32'h0, dat2}; obs_strobe = {4'h0, stb2};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: place each store byte individually by its own address.
  task automatic model(input int bb, input bit split, input logic [63:0] addr,
                       input logic [63:0] data, input int size);
    logic [63:0] base0, rel;
    int          idx, lane;
    bit          crossing;
    base0 = addr & ~64'(bb - 1);
    e_addr[0] = base0;
    e_addr[1] = base0 + 64'(bb);
    e_data[0] = '0; e_data[1] = '0; e_strb[0] = '0; e_strb[1] = '0;
    crossing = 1'b0;
    for (int k = 0; k < size; k++) begin
      rel  = addr + 64'(k) - base0;
      idx  = int'(rel) / bb;
      lane = int'(rel) % bb;
      if (idx > 0) crossing = 1'b1;
      if (idx < 2) begin
        e_data[idx][8*lane +: 8] = data[8*k +: 8];
        e_strb[idx][lane] = 1'b1;
      end
    end
    e_illegal = (crossing && !split) || (size > bb && (addr % 64'(bb)) != 0);
    e_nb = e_illegal ? 0 : (crossing ? 2 : 1);
  endtask

  // Issue one store on instance s and play the bus with the given ready/response delays.
  task automatic run_store(input int s, input logic [63:0] a, input logic [63:0] d,
                           input int msz, input int rdly, input int pdly);
    int cyc, beat_sent, hold, rcnt, idx, exp_lat;
    bit got_done, in_wait;
    sel = s;
    model((s == 2) ? 4 : 8, s != 1, a, d, 1 << msz);
    exp_lat = e_illegal ? 1 : 1 + e_nb * (2 + rdly + pdly);
    for (int i = 0; i < 2; i++) begin ob_addr[i] = '0; ob_data[i] = '0; ob_strb[i] = '0; end
    cyc = 0; beat_sent = 0; hold = 0; rcnt = 0; got_done = 0; in_wait = 0;
    #1;
    chk("in_ready_idle", 64'(obs_ready), 64'd1);
    in_addr = a; in_data = d; in_msize = msize_t'(msz); in_valid = 1'b1;
    for (int c = 0; c < 60 && !got_done; c++) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0; req_ready = 1'b0; resp_ok = 1'b0;
      if (obs_done) begin
        got_done = 1'b1;
        chk("misalign", 64'(obs_mis), 64'(e_illegal));
        chk("beat_count", 64'(beat_sent), 64'(e_nb));
        chk("latency", 64'(cyc), 64'(exp_lat));
      end else begin
        chk("busy_not_ready", 64'(obs_ready), 64'd0);
        if (obs_valid) begin
          chk("beat_expected", 64'(beat_sent < e_nb), 64'd1);
          idx = (beat_sent > 1) ? 1 : beat_sent;
          chk("beat_addr", obs_addr, e_addr[idx]);
          chk("beat_data", obs_data, e_data[idx]);
          chk("beat_strobe", 64'(obs_strobe), 64'(e_strb[idx]));
          resp_ok = 1'($urandom_range(0, 1));
          if (hold < rdly) hold++;
          else begin
            req_ready = 1'b1;
            ob_addr[idx] = obs_addr; ob_data[idx] = obs_data; ob_strb[idx] = obs_strobe;
            beat_sent++; hold = 0; in_wait = 1'b1;
          end
        end else if (in_wait) begin
          req_ready = 1'($urandom_range(0, 1));
          if (rcnt < pdly) rcnt++;
          else begin resp_ok = 1'b1; rcnt = 0; in_wait = 1'b0; end
        end
      end
    end
    chk("done_seen", 64'(got_done), 64'd1);
    @(negedge clk);
    req_ready = 1'b0; resp_ok = 1'b0;
    chk("done_one_cycle", 64'(obs_done), 64'd0);
    chk("ready_after", 64'(obs_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] ra, rd;
    reset = 1'b1; in_valid = 1'b0; req_ready = 1'b0; resp_ok = 1'b0;
    in_addr = '0; in_data = '0; in_msize = MSIZE1; sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(obs_ready), 64'd1);
    chk("rst_valid", 64'(obs_valid), 64'd0);
    chk("rst_addr", obs_addr, 64'd0);
    chk("rst_data", obs_data, 64'd0);
    chk("rst_done", 64'(obs_done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_store(0, 64'h1003, 64'hAB, 0, 0, 0);
    chk("b1_addr", ob_addr[0], 64'h1000);
    chk("b1_strobe", 64'(ob_strb[0]), 64'h08);
    chk("b1_data", ob_data[0], 64'h00000000AB000000);

    run_store(0, 64'h2006, 64'h11223344, 2, 0, 0);
    chk("split_b0_addr", ob_addr[0], 64'h2000);
    chk("split_b0_strobe", 64'(ob_strb[0]), 64'hC0);
    chk("split_b0_data", 64'(ob_data[0][63:48]), 64'h3344);
    chk("split_b1_addr", ob_addr[1], 64'h2008);
    chk("split_b1_strobe", 64'(ob_strb[1]), 64'h03);
    chk("split_b1_data", 64'(ob_data[1][15:0]), 64'h1122);

    run_store(1, 64'h2006, 64'h11223344, 2, 0, 0);

    run_store(0, 64'h3000, 64'h0123456789ABCDEF, 3, 3, 0);
    chk("stall_strobe", 64'(ob_strb[0]), 64'hFF);

    run_store(2, 64'h4000, 64'h8877665544332211, 3, 0, 0);
    chk("bb4_b0_addr", ob_addr[0], 64'h4000);
    chk("bb4_b0_strobe", 64'(ob_strb[0]), 64'hF);
    chk("bb4_b0_data", ob_data[0], 64'h44332211);
    chk("bb4_b1_addr", ob_addr[1], 64'h4004);
    chk("bb4_b1_strobe", 64'(ob_strb[1]), 64'hF);
    chk("bb4_b1_data", ob_data[1], 64'h88776655);

    run_store(0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hDEADBEEF, 2, 1, 1);
    chk("wrap_b1_addr", ob_addr[1], 64'h0);
    run_store(2, 64'h4002, 64'h1122334455667788, 3, 0, 0);
    run_store(0, 64'h5003, 64'hFFEEDDCCBBAA9988, 3, 0, 2);
    run_store(1, 64'h6004, 64'hCAFEF00D, 2, 0, 0);

    // Reset while the second beat's response is outstanding.
    sel = 0;
    in_addr = 64'h2006; in_data = 64'h11223344; in_msize = MSIZE4;
    in_valid = 1'b1; req_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); resp_ok = 1'b1;
    @(negedge clk); resp_ok = 1'b0;
    @(negedge clk);
    chk("wait1_not_ready", 64'(obs_ready), 64'd0);
    chk("wait1_not_valid", 64'(obs_valid), 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(obs_ready), 64'd1);
    chk("mid_rst_valid", 64'(obs_valid), 64'd0);
    chk("mid_rst_addr", obs_addr, 64'd0);
    chk("mid_rst_data", obs_data, 64'd0);
    chk("mid_rst_strobe", 64'(obs_strobe), 64'd0);
    chk("mid_rst_done", 64'(obs_done), 64'd0);
    chk("mid_rst_misalign", 64'(obs_mis), 64'd0);
    @(negedge clk);
    reset = 1'b0; req_ready = 1'b0; resp_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", 64'(obs_done), 64'd0);
      chk("post_rst_ready", 64'(obs_ready), 64'd1);
    end
    resp_ok = 1'b0;
    run_store(0, 64'h7005, 64'h5A5A, 1, 0, 0);

    for (int n = 0; n < 60; n++) begin
      ra = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) ra[63:4] = '1;
      run_store(int'($urandom_range(0, 2)), ra, rd, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
